instr_fetch: RTL and testbench

Instruction fetch and prefetch stage directly upstream of `control`. It takes the next-instruction address that `control` drives on `Address_Instruction_Bus` and fetches 9-bit microinstruction words from instruction memory over a req/ack handshake. It keeps a small prefetch buffer of sequential words and delivers the requested word to `control` on `ms_m`. Non-sequential addresses (jumps) flush the buffer and redirect fetching.

---
 rtl/instr_fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/instr_fetch.sv | 153 +++++++++++++++
 tb/tb_instr_fetch.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch/prefetch stage: default widths,
// FSM state encoding and the prefetch buffer entry layout.
package instr_fetch_pkg;

    localparam int AW_DEF = 8;
    localparam int IW_DEF = 9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [AW_DEF-1:0] addr;
        logic [IW_DEF-1:0] word;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small prefetch FIFO of {addr, word} entries in fetch order.
// Flush wins over push; push and pop together are accepted while full.
module fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int W     = AW_DEF + IW_DEF,
    parameter int DEPTH = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    input  logic         i_flush,
    output logic [W-1:0] o_head,
    output logic         o_head_valid,
    output logic         o_full,
    output logic         o_almost_full
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [PW:0]   r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_head_valid  = (r_count != '0);
    assign o_full        = (r_count == (PW+1)'(DEPTH));
    assign o_almost_full = (r_count == (PW+1)'(DEPTH - 1));
    assign o_head        = r_mem[r_rd];

    assign w_do_pop  = i_pop && o_head_valid && !i_flush;
    assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + PW'(1);
            if (w_do_pop)  r_rd <= r_rd + PW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch/prefetch: streams sequential words from memory into a small
// buffer, serves strobed addresses from it and redirects on non-sequential ones.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int IW    = IW_DEF,
    parameter int DEPTH = 2
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic [AW-1:0] Address_Instruction_Bus,
    input  logic          Addr_Strobe,
    output logic [IW-1:0] ms_m,
    output logic          ms_valid,
    output logic [AW-1:0] mem_addr,
    output logic          mem_req,
    input  logic          mem_ack,
    input  logic [IW-1:0] mem_data
);

    localparam int EW = AW + IW;

    fetch_state_t  r_state;
    logic [AW-1:0] r_fpc;
    logic [AW-1:0] r_mem_addr;
    logic          r_mem_req;
    logic          r_pend_valid;
    logic [AW-1:0] r_pend_addr;
    logic [IW-1:0] r_ms_m;
    logic          r_ms_valid;

    logic [EW-1:0] w_head;
    logic [AW-1:0] w_head_addr;
    logic [IW-1:0] w_head_word;
    logic          w_head_valid;
    logic          w_full;
    logic          w_afull;
    logic          w_hit;
    logic          w_miss;
    logic          w_deliver;
    logic          w_pop;
    logic          w_keep;
    logic          w_redirect;
    logic          w_push;
    logic          w_room;
    logic          w_full_after;
    logic [AW-1:0] w_next_addr;

    assign w_head_addr = w_head[EW-1:IW];
    assign w_head_word = w_head[IW-1:0];

    assign w_hit     = Addr_Strobe && w_head_valid && (w_head_addr == Address_Instruction_Bus);
    assign w_miss    = Addr_Strobe && !w_hit;
    assign w_deliver = !Addr_Strobe && r_pend_valid && w_head_valid && (w_head_addr == r_pend_addr);
    assign w_pop     = w_hit || w_deliver;

    // An in-flight request for the missed address is reused only if its data
    // is still to come; a same-cycle ack is lost to the flush, so refetch.
    assign w_keep     = (r_state == S_REQ) && !mem_ack && (r_mem_addr == Address_Instruction_Bus);
    assign w_redirect = w_miss && !w_keep;

    assign w_push       = (r_state == S_REQ) && mem_ack && !w_miss;
    assign w_room       = !w_full || w_pop;
    assign w_full_after = !w_pop && (w_afull || w_full);
    assign w_next_addr  = r_mem_addr + AW'(1);

    fetch_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk         (Clk),
        .i_rst_n       (Rst),
        .i_push        (w_push),
        .i_data        ({r_mem_addr, mem_data}),
        .i_pop         (w_pop),
        .i_flush       (w_miss),
        .o_head        (w_head),
        .o_head_valid  (w_head_valid),
        .o_full        (w_full),
        .o_almost_full (w_afull)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state      <= S_IDLE;
            r_fpc        <= '0;
            r_mem_addr   <= '0;
            r_mem_req    <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
            r_ms_m       <= '0;
            r_ms_valid   <= 1'b0;
        end else begin
            r_ms_valid <= w_pop;
            if (w_pop) r_ms_m <= w_head_word;

            if (Addr_Strobe) begin
                r_pend_valid <= w_miss;
                r_pend_addr  <= Address_Instruction_Bus;
            end else if (w_deliver) begin
                r_pend_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_redirect) begin
                        r_fpc      <= Address_Instruction_Bus;
                        r_mem_addr <= Address_Instruction_Bus;
                        r_mem_req  <= 1'b1;
                        r_state    <= S_REQ;
                    end else if (w_room) begin
                        r_mem_addr <= r_fpc;
                        r_mem_req  <= 1'b1;
                        r_state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (w_redirect) begin
                        r_fpc <= Address_Instruction_Bus;
                        if (mem_ack) r_mem_addr <= Address_Instruction_Bus;
                        else         r_state    <= S_DROP;
                    end else if (mem_ack) begin
                        r_fpc <= w_next_addr;
                        if (w_full_after) begin
                            r_mem_req <= 1'b0;
                            r_state   <= S_IDLE;
                        end else begin
                            r_mem_addr <= w_next_addr;
                        end
                    end
                end
                S_DROP: begin
                    if (w_redirect) r_fpc <= Address_Instruction_Bus;
                    if (mem_ack) begin
                        r_mem_addr <= w_redirect ? Address_Instruction_Bus : r_fpc;
                        r_state    <= S_REQ;
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign ms_m     = r_ms_m;
    assign ms_valid = r_ms_valid;
    assign mem_addr = r_mem_addr;
    assign mem_req  = r_mem_req;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed latency scenarios, then randomized strobes
// against a memory image and a "last strobed address" delivery model.
module tb_instr_fetch;

    localparam int AW = 8;
    localparam int IW = 9;

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic [AW-1:0] Address_Instruction_Bus = '0;
    logic          Addr_Strobe = 1'b0;
    logic [IW-1:0] ms_m;
    logic          ms_valid;
    logic [AW-1:0] mem_addr;
    logic          mem_req;
    logic          mem_ack = 1'b0;
    logic [IW-1:0] mem_data = '0;

    int n_checks = 0;
    int n_errors = 0;

    logic [IW-1:0] mem [256];
    int            wait_cfg  = 0;
    bit            rand_wait = 1'b0;

    int            m_left = 0;
    bit            m_busy = 1'b0;
    logic [AW-1:0] m_addr = '0;

    instr_fetch #(.AW(AW), .IW(IW), .DEPTH(2)) dut (
        .Clk                     (Clk),
        .Rst                     (Rst),
        .Address_Instruction_Bus (Address_Instruction_Bus),
        .Addr_Strobe             (Addr_Strobe),
        .ms_m                    (ms_m),
        .ms_valid                (ms_valid),
        .mem_addr                (mem_addr),
        .mem_req                 (mem_req),
        .mem_ack                 (mem_ack),
        .mem_data                (mem_data)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    // Memory: each request is acked after its wait count, data valid only with ack.
    initial begin
        forever begin
            @(posedge Clk);
            #1;
            if (Rst && mem_req) begin
                if (!m_busy) begin
                    m_busy = 1'b1;
                    m_left = rand_wait ? int'($urandom_range(0, 3)) : wait_cfg;
                    m_addr = mem_addr;
                end else begin
                    check("mem_addr_stable", 32'(mem_addr), 32'(m_addr));
                end
                if (m_left == 0) begin
                    mem_ack  = 1'b1;
                    mem_data = mem[mem_addr];
                    m_busy   = 1'b0;
                end else begin
                    mem_ack  = 1'b0;
                    mem_data = ~mem[mem_addr];
                    m_left--;
                end
            end else begin
                mem_ack  = 1'b0;
                mem_data = '0;
                m_busy   = 1'b0;
            end
        end
    end

    initial begin
        logic [AW-1:0] last;
        logic [AW-1:0] nxt;
        bit            outstanding;
        bit            do_strobe;
        int            age;

        for (int i = 0; i < 256; i++) mem[i] = IW'($urandom_range(1, 511));
        mem[8'h05] = 9'h0A5;
        mem[8'h80] = 9'h15A;

        // Reset state
        repeat (3) tick();
        check("rst_ms_m",     32'(ms_m),     32'h0);
        check("rst_ms_valid", 32'(ms_valid), 32'h0);
        check("rst_mem_req",  32'(mem_req),  32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);

        // Priming with zero-wait memory
        Rst = 1'b1;
        tick();
        check("first_req",  32'(mem_req),  32'h1);
        check("first_addr", 32'(mem_addr), 32'h0);
        tick();
        check("second_addr", 32'(mem_addr), 32'h1);
        tick();
        check("full_idle", 32'(mem_req), 32'h0);
        tick();
        check("hold_idle", 32'(mem_req), 32'h0);

        // Sequential stream of hits
        for (int i = 0; i < 4; i++) begin
            Addr_Strobe = 1'b1;
            Address_Instruction_Bus = AW'(i);
            tick();
            check("stream_valid", 32'(ms_valid), 32'h1);
            check("stream_word",  32'(ms_m),     32'(mem[AW'(i)]));
        end
        Addr_Strobe = 1'b0;
        tick();
        check("stream_end_valid", 32'(ms_valid), 32'h0);
        tick();
        check("stream_refill_idle", 32'(mem_req), 32'h0);

        // Jump to 0x40
        Addr_Strobe = 1'b1;
        Address_Instruction_Bus = 8'h40;
        tick();
        Addr_Strobe = 1'b0;
        check("jump_addr",     32'(mem_addr), 32'h40);
        check("jump_req",      32'(mem_req),  32'h1);
        check("jump_no_valid", 32'(ms_valid), 32'h0);
        tick();
        check("jump_wait", 32'(ms_valid), 32'h0);
        tick();
        check("jump_valid", 32'(ms_valid), 32'h1);
        check("jump_word",  32'(ms_m),     32'(mem[8'h40]));
        tick();
        tick();

        // Redirect to 0x80 during a 3-wait fetch of 0x05
        wait_cfg = 3;
        Addr_Strobe = 1'b1;
        Address_Instruction_Bus = 8'h05;
        tick();
        check("redir_first_addr", 32'(mem_addr), 32'h05);
        Address_Instruction_Bus = 8'h80;
        tick();
        Addr_Strobe = 1'b0;
        wait_cfg = 0;
        check("drop_addr_held", 32'(mem_addr), 32'h05);
        check("drop_req_held",  32'(mem_req),  32'h1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("drop_addr_wait", 32'(mem_addr), 32'h05);
            check("drop_no_valid",  32'(ms_valid), 32'h0);
        end
        tick();
        check("redir_addr80",   32'(mem_addr), 32'h80);
        check("redir_no_valid", 32'(ms_valid), 32'h0);
        tick();
        check("redir_wait", 32'(ms_valid), 32'h0);
        tick();
        check("redir_valid", 32'(ms_valid), 32'h1);
        check("redir_word",  32'(ms_m),     32'(mem[8'h80]));
        tick();
        tick();

        // Wrap-around FF -> 00
        Addr_Strobe = 1'b1;
        Address_Instruction_Bus = 8'hFF;
        tick();
        Addr_Strobe = 1'b0;
        tick();
        check("wrap_fetch_00", 32'(mem_addr), 32'h00);
        tick();
        check("wrap_ff_valid", 32'(ms_valid), 32'h1);
        check("wrap_ff_word",  32'(ms_m),     32'(mem[8'hFF]));
        Addr_Strobe = 1'b1;
        Address_Instruction_Bus = 8'h00;
        tick();
        Addr_Strobe = 1'b0;
        check("wrap_hit_valid", 32'(ms_valid), 32'h1);
        check("wrap_hit_word",  32'(ms_m),     32'(mem[8'h00]));
        check("pre_rst_req",    32'(mem_req),  32'h1);

        // Asynchronous reset mid-transaction
        Rst = 1'b0;
        #1;
        check("async_rst_req",   32'(mem_req),  32'h0);
        check("async_rst_valid", 32'(ms_valid), 32'h0);
        check("async_rst_ms_m",  32'(ms_m),     32'h0);
        tick();
        tick();
        Rst = 1'b1;
        tick();
        check("restart_req",  32'(mem_req),  32'h1);
        check("restart_addr", 32'(mem_addr), 32'h0);
        tick();
        tick();
        Addr_Strobe = 1'b1;
        Address_Instruction_Bus = 8'h00;
        tick();
        Addr_Strobe = 1'b0;
        check("restart_hit_valid", 32'(ms_valid), 32'h1);
        check("restart_hit_word",  32'(ms_m),     32'(mem[8'h00]));

        // Randomized strobes: every delivery must carry mem[last strobed address]
        rand_wait   = 1'b1;
        last        = 8'h00;
        nxt         = 8'h00;
        outstanding = 1'b0;
        age         = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            do_strobe = outstanding ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) != 0);
            if (do_strobe) nxt = ($urandom_range(0, 3) != 0) ? last + 8'd1 : AW'($urandom);
            Addr_Strobe = do_strobe;
            Address_Instruction_Bus = nxt;
            tick();
            Addr_Strobe = 1'b0;
            if (do_strobe) begin
                last        = nxt;
                outstanding = 1'b1;
                age         = 0;
            end
            if (ms_valid) begin
                check("rnd_expected", 32'(outstanding), 32'h1);
                check("rnd_word",     32'(ms_m),        32'(mem[last]));
                outstanding = 1'b0;
            end else if (outstanding) begin
                age++;
                check("rnd_latency_bound", 32'(age > 40), 32'h0);
                if (age > 40) outstanding = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
